// File: rtl/write_interface.sv
// -----------------------------------------------------------------------------
// write_interface
//
// Write-side front end of the synchronous shadow-model FIFO. It owns the write
// pointer and gates write requests against the full condition. It drives the
// storage array's write port. It also derives full, almost_full, fill_level and
// a sticky overflow flag by comparing its own pointer with the read pointer.
// The read-side block supplies that read pointer from the same clock domain.
//
// Parameters
//   DATA_WIDTH  width of a FIFO word
//   ADDR_WIDTH  storage address width, DEPTH = 2**ADDR_WIDTH
//   AF_MARGIN   almost_full asserts when free slots <= AF_MARGIN (1..DEPTH-1)
//
// Ports
//   clk             single clock, rising edge
//   rstn            asynchronous active-low reset
//   write_en        write request for this cycle
//   write_data      word to store
//   read_addr       read pointer from the read side, MSB is the wrap bit
//   clear_overflow  single-cycle clear of the overflow flag
//   write_addr      write pointer, MSB is the wrap bit
//   mem_write_en    storage write strobe (write_en && !full)
//   mem_write_data  write_data, passed straight through
//   full            FIFO holds DEPTH words
//   almost_full     fill_level >= DEPTH - AF_MARGIN
//   fill_level      number of stored words, 0..DEPTH
//   overflow        sticky, set when a write is attempted while full
//   drop_count      16-bit saturating count of rejected writes
//                   (present only when WRITE_IF_DROP_CNT_EN is defined)
//
// Build option
//   WRITE_IF_DROP_CNT_EN  adds the drop_count port and its register.
//                         Nothing else changes when it is defined.
// -----------------------------------------------------------------------------
module write_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH:0]   read_addr,
    input  logic                  clear_overflow,
    output logic [ADDR_WIDTH:0]   write_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_level,
`ifdef WRITE_IF_DROP_CNT_EN
    output logic                  overflow,
    output logic [15:0]           drop_count
`else
    output logic                  overflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // fill_level at or above this value means at most AF_MARGIN free slots.
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

    logic reject;

    // -------------------------------------------------------------------------
    // Status derived combinationally from the registered pointers.
    // The extra wrap bit separates full from empty when the low address bits
    // match. Unsigned modular subtraction gives the occupancy directly, and it
    // stays correct across the 2**(ADDR_WIDTH+1)-1 -> 0 pointer wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        full = (write_addr[ADDR_WIDTH] != read_addr[ADDR_WIDTH]) &&
               (write_addr[ADDR_WIDTH-1:0] == read_addr[ADDR_WIDTH-1:0]);
    end

    assign fill_level  = write_addr - read_addr;
    assign almost_full = full || (fill_level >= AF_THRESH);

    // Accept/reject gating. full comes only from registered pointers, so a read
    // in the same cycle cannot let a write through while the FIFO is full.
    assign mem_write_en   = write_en && !full;
    assign mem_write_data = write_data;
    assign reject         = write_en && full;

    // -------------------------------------------------------------------------
    // Write pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_addr <= '0;
        end else if (mem_write_en) begin
            write_addr <= write_addr + PTR_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow: a set in the same cycle wins over clear_overflow
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (reject) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef WRITE_IF_DROP_CNT_EN
    // -------------------------------------------------------------------------
    // Rejected-write counter. It saturates at all-ones. When a clear and a
    // reject share a cycle, the clear happens first and the reject is then
    // counted, so the result is 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_count <= 16'h0000;
        end else if (reject) begin
            if (clear_overflow) begin
                drop_count <= 16'h0001;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'h0001;
            end
        end else if (clear_overflow) begin
            drop_count <= 16'h0000;
        end
    end
`endif

endmodule

// File: tb/tb_write_interface.sv
module tb_write_interface;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AFM = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [AW:0]   read_addr;
    logic          clear_overflow;
    logic [AW:0]   write_addr;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic          full;
    logic          almost_full;
    logic [AW:0]   fill_level;
    logic          overflow;
`ifdef WRITE_IF_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    write_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
        .clk(clk),
        .rstn(rstn),
        .write_en(write_en),
        .write_data(write_data),
        .read_addr(read_addr),
        .clear_overflow(clear_overflow),
        .write_addr(write_addr),
        .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data),
        .full(full),
        .almost_full(almost_full),
        .fill_level(fill_level),
`ifdef WRITE_IF_DROP_CNT_EN
        .overflow(overflow),
        .drop_count(drop_count)
`else
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    // Expected per-cycle status and expected storage writes
    typedef struct {
        int mwe;
        int waddr;
        int wdata;
        int full;
        int af;
        int fill;
        int ovf;
        int drop;
    } status_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    status_t st_q[$];
    wr_t     wr_q[$];

    // Reference model: contents as a queue of words, plus counters
    int m_data[$];
    int m_writes;     // accepted writes since reset, modulo 2*DEPTH
    int m_reads;      // reads since reset, modulo 2*DEPTH
    int m_ovf;
    int m_drop;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data.delete();
        m_writes = 0;
        m_reads  = 0;
        m_ovf    = 0;
        m_drop   = 0;
    endtask

    // One clock cycle of stimulus. Called just after a rising edge.
    task automatic step(input bit we, input int wd, input bit rd, input bit clr, input bit rst_lo);
        status_t s;
        wr_t     w;
        bit      acc;
        bit      rej;
        rstn           = !rst_lo;
        write_en       = we;
        write_data     = DW'(wd);
        clear_overflow = clr;
        if (rst_lo) begin
            model_reset();
            read_addr = '0;
            s.mwe = int'(we); s.waddr = 0; s.wdata = wd; s.full = 0; s.af = 0;
            s.fill = 0; s.ovf = 0; s.drop = 0;
            st_q.push_back(s);
            @(posedge clk);
            #1;
        end else begin
            acc = we && (m_data.size() < DEPTH);
            rej = we && (m_data.size() == DEPTH);
            s.mwe   = int'(acc);
            s.waddr = m_writes;
            s.wdata = wd;
            s.full  = int'(m_data.size() == DEPTH);
            s.af    = int'(m_data.size() >= DEPTH - AFM);
            s.fill  = m_data.size();
            s.ovf   = m_ovf;
            s.drop  = m_drop;
            st_q.push_back(s);
            if (acc) begin
                w.addr = m_writes % DEPTH;
                w.data = wd;
                wr_q.push_back(w);
            end
            // Next-state of the model
            if (rd && m_data.size() > 0) begin
                void'(m_data.pop_front());
                m_reads = (m_reads + 1) % (2 * DEPTH);
            end
            if (acc) begin
                m_data.push_back(wd);
                m_writes = (m_writes + 1) % (2 * DEPTH);
            end
            if (rej) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (rej) m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
            else if (clr) m_drop = 0;
            @(posedge clk);
            #1;
            read_addr = (AW + 1)'(m_reads);
        end
    endtask

    // Monitor: compares whatever the DUT presents in mid-cycle
    always @(negedge clk) begin
        status_t e;
        wr_t     w;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("mem_write_en",   int'(mem_write_en),   e.mwe);
            chk("write_addr",     int'(write_addr),     e.waddr);
            chk("mem_write_data", int'(mem_write_data), e.wdata);
            chk("full",           int'(full),           e.full);
            chk("almost_full",    int'(almost_full),    e.af);
            chk("fill_level",     int'(fill_level),     e.fill);
            chk("overflow",       int'(overflow),       e.ovf);
`ifdef WRITE_IF_DROP_CNT_EN
            chk("drop_count",     int'(drop_count),     e.drop);
`endif
        end
        if (rstn && mem_write_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_mem_write", 1, 0);
            end else begin
                w = wr_q.pop_front();
                chk("mem_addr", int'(write_addr[AW-1:0]), w.addr);
                chk("mem_data", int'(mem_write_data),     w.data);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit we, rd, clr, rl;
        rstn = 1'b0;
        write_en = 1'b0;
        write_data = '0;
        read_addr = '0;
        clear_overflow = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1);
        step(1, 8'h33, 0, 0, 1);   // mem_write_en follows write_en during reset

        // Eight back-to-back writes fill the FIFO
        for (int i = 0; i < 8; i++) step(1, 8'h10 + i, 0, 0, 0);
        // Rejected write while full, then observe overflow
        step(1, 8'hAA, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Read and write in the same cycle while full: write rejected
        step(1, 8'hBB, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 8'h55, 0, 0, 0);   // lands at address 0, pointer goes to 9
        step(0, 0, 0, 0, 0);
        // Overflow set and clear together, then clear alone
        step(1, 8'hCC, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Drain to 3 words, then stream with reads through the pointer wrap
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'h60 + i, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset mid-burst at write_addr 5
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'h70 + i, 0, 0, 0);
        step(1, 8'h7F, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'h80 + i, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            we  = ($urandom_range(0, 99) < 60);
            rd  = ($urandom_range(0, 99) < 40) && (m_data.size() > 0);
            clr = ($urandom_range(0, 99) < 8);
            rl  = ($urandom_range(0, 199) == 0);
            step(we, int'($urandom_range(0, 255)), rd, clr, rl);
        end
        step(0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("pending_mem_writes", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
